// File: rtl/rect_ctl_pkg.sv
// Shared types and constants for the falling-rectangle control path.
package rect_ctl_pkg;

    typedef enum logic [2:0] {
        FOLLOW = 3'd0,
        FALL   = 3'd1,
        IMPACT = 3'd2,
        RISE   = 3'd3,
        REST   = 3'd4
    } drop_state_t;

    localparam int VISIBLE_HEIGHT = 600;
    localparam int RECT_HEIGHT    = 64;

    // Increment that sticks at lim instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
        return (v < lim) ? v + 4'd1 : lim;
    endfunction

endpackage

// File: rtl/rect_drop_seq_debounce.sv
// Mouse button conditioning: 2-FF synchroniser, stable-level debouncer and a
// registered one-cycle pulse on each accepted press.
module click_debounce
    import rect_ctl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 40_000
) (
    input  logic clk,
    input  logic rst,
    input  logic mouse_left,
    output logic click
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // blocking here would collapse the synchroniser into a single stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            click <= 1'b0;
        end else begin
            sync1 <= mouse_left;
            sync2 <= sync1;
            click <= 1'b0;
            // Any sample equal to the accepted level restarts the stability run.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                level <= sync2;
                cnt   <= '0;
                click <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/rect_drop_seq.sv
// Control sequencer for the falling rectangle: click conditioning, physics tick
// and the FOLLOW/FALL/IMPACT/RISE/REST state machine driving the datapath.
module rect_drop_seq
    import rect_ctl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 40_000,
    parameter int TICK_DIV     = 1,
    parameter int MAX_BOUNCES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mouse_left,
    input  logic       vsync,
    input  logic       at_floor,
    input  logic       apex,
    input  logic       vel_small,
    output logic       follow,
    output logic       step_en,
    output logic       dir_up,
    output logic       load_floor,
    output logic       halve_vel,
    output logic       clr_vel,
    output logic [3:0] bounce_cnt,
    output logic [2:0] state_o
);

    localparam int         FW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [3:0] BOUNCE_LIM = 4'(MAX_BOUNCES);

    logic click;

    click_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_click_debounce (
        .clk       (clk),
        .rst       (rst),
        .mouse_left(mouse_left),
        .click     (click)
    );

    // ---------------- physics tick ----------------
    logic          vsync_d;
    logic [FW-1:0] frame_cnt;
    logic          vs_rise;
    logic          tick;

    assign vs_rise = vsync & ~vsync_d;
    assign tick    = vs_rise && (frame_cnt == FW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vsync_d <= vsync;
            if (vs_rise) begin
                frame_cnt <= tick ? '0 : frame_cnt + FW'(1);
            end
        end
    end

    // ---------------- sequencer ----------------
    drop_state_t state;
    drop_state_t state_nxt;
    logic        click_pending;
    logic        pending;
    logic        consume;
    logic        step_nxt;
    logic [3:0]  bounce_nxt;

    // A click landing this very cycle is served without waiting a cycle.
    assign pending = click_pending | click;

    // NOTE: every signal driven here gets a default before the case, so no
    // path can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        step_nxt   = 1'b0;
        consume    = 1'b0;
        bounce_nxt = bounce_cnt;
        case (state)
            FOLLOW: begin
                if (pending) begin
                    state_nxt  = FALL;
                    bounce_nxt = 4'd0;
                    consume    = 1'b1;
                end
            end
            FALL: begin
                if (pending) begin
                    state_nxt = FOLLOW;
                    consume   = 1'b1;
                end else if (tick) begin
                    if (at_floor) begin
                        state_nxt  = IMPACT;
                        bounce_nxt = sat_inc(bounce_cnt, BOUNCE_LIM);
                    end else begin
                        step_nxt = 1'b1;
                    end
                end
            end
            IMPACT: begin
                // bounce_cnt already holds the post-impact count here.
                state_nxt = (vel_small || bounce_cnt == BOUNCE_LIM) ? REST : RISE;
            end
            RISE: begin
                if (pending) begin
                    state_nxt = FOLLOW;
                    consume   = 1'b1;
                end else if (tick) begin
                    if (apex) begin
                        state_nxt = FALL;
                    end else begin
                        step_nxt = 1'b1;
                    end
                end
            end
            REST: begin
                if (pending) begin
                    state_nxt = FOLLOW;
                    consume   = 1'b1;
                end
            end
            default: begin
                state_nxt = FOLLOW;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FOLLOW;
            click_pending <= 1'b0;
            bounce_cnt    <= 4'd0;
            follow        <= 1'b1;
            clr_vel       <= 1'b1;
            step_en       <= 1'b0;
            dir_up        <= 1'b0;
            load_floor    <= 1'b0;
            halve_vel     <= 1'b0;
        end else begin
            state         <= state_nxt;
            click_pending <= pending & ~consume;
            bounce_cnt    <= bounce_nxt;
            follow        <= (state_nxt == FOLLOW);
            clr_vel       <= (state_nxt == FOLLOW) || (state_nxt == REST);
            step_en       <= step_nxt;
            dir_up        <= (state_nxt == RISE);
            load_floor    <= (state_nxt == IMPACT);
            halve_vel     <= (state_nxt == IMPACT);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_rect_drop_seq.sv
// Self-checking bench for rect_drop_seq: directed scenarios plus a randomized
// flight against a per-event reference model.
module tb_rect_drop_seq;
    import rect_ctl_pkg::*;

    localparam int DEB       = 4;
    localparam int TDIV      = 2;
    localparam int MAXB      = 3;
    localparam int CLICK_LAT = 2 + DEB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mouse_left = 1'b0;
    logic       vsync = 1'b0;
    logic       at_floor = 1'b0;
    logic       apex = 1'b0;
    logic       vel_small = 1'b0;
    logic       follow, step_en, dir_up, load_floor, halve_vel, clr_vel;
    logic [3:0] bounce_cnt;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    rect_drop_seq #(
        .DEBOUNCE_CYC(DEB),
        .TICK_DIV    (TDIV),
        .MAX_BOUNCES (MAXB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mouse_left(mouse_left),
        .vsync     (vsync),
        .at_floor  (at_floor),
        .apex      (apex),
        .vel_small (vel_small),
        .follow    (follow),
        .step_en   (step_en),
        .dir_up    (dir_up),
        .load_floor(load_floor),
        .halve_vel (halve_vel),
        .clr_vel   (clr_vel),
        .bounce_cnt(bounce_cnt),
        .state_o   (state_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Pulse monitor: running totals that the scenario tasks difference.
    int   step_seen = 0, up_seen = 0, load_seen = 0, halve_seen = 0;
    int   long_seen = 0, overlap_seen = 0;
    logic step_q = 1'b0, load_q = 1'b0;
    always @(negedge clk) begin
        if (step_en === 1'b1) begin
            step_seen++;
            if (dir_up === 1'b1) up_seen++;
        end
        if (load_floor === 1'b1) load_seen++;
        if (halve_vel === 1'b1) halve_seen++;
        if ((step_en === 1'b1 && step_q) || (load_floor === 1'b1 && load_q)) long_seen++;
        if (step_en === 1'b1 && (load_floor === 1'b1 || halve_vel === 1'b1)) overlap_seen++;
        step_q = (step_en === 1'b1);
        load_q = (load_floor === 1'b1);
    end

    // Reference model: flight mode, impact count and frame phase.
    typedef enum {M_FOLLOW, M_FALL, M_RISE, M_REST} mode_t;
    mode_t m_mode   = M_FOLLOW;
    int    m_bounce = 0;
    int    m_frames = 0;

    function automatic drop_state_t m_enc(input mode_t m);
        case (m)
            M_FALL:  return FALL;
            M_RISE:  return RISE;
            M_REST:  return REST;
            default: return FOLLOW;
        endcase
    endfunction

    function automatic void m_reset();
        m_mode   = M_FOLLOW;
        m_bounce = 0;
        m_frames = 0;
    endfunction

    function automatic void m_click();
        if (m_mode == M_FOLLOW) begin
            m_mode   = M_FALL;
            m_bounce = 0;
        end else begin
            m_mode = M_FOLLOW;
        end
    endfunction

    // One vsync pulse with datapath flags held from its rising edge onward.
    task automatic do_vsync(input logic af, input logic ap, input logic vs,
                            output int exp_step, output int exp_up, output int exp_load);
        bit is_tick;
        is_tick  = (m_frames == TDIV - 1);
        m_frames = (m_frames + 1) % TDIV;
        exp_step = 0;
        exp_load = 0;
        @(posedge clk); #1;
        vsync = 1'b1; at_floor = af; apex = ap; vel_small = vs;
        @(posedge clk); #1;
        vsync = 1'b0;
        repeat (3) @(posedge clk);
        if (is_tick) begin
            case (m_mode)
                M_FALL: begin
                    if (af) begin
                        m_bounce = (m_bounce < MAXB) ? m_bounce + 1 : MAXB;
                        m_mode   = (vs || m_bounce == MAXB) ? M_REST : M_RISE;
                        exp_load = 1;
                    end else begin
                        exp_step = 1;
                    end
                end
                M_RISE: begin
                    if (ap) m_mode = M_FALL;
                    else    exp_step = 1;
                end
                default: ;
            endcase
        end
        exp_up = (exp_step == 1 && m_mode == M_RISE) ? 1 : 0;
    endtask

    // Clean press held past acceptance, then a clean release.
    task automatic do_click();
        @(posedge clk); #1;
        mouse_left = 1'b1;
        repeat (CLICK_LAT) @(posedge clk);
        #1;
        mouse_left = 1'b0;
        repeat (DEB + 4) @(posedge clk);
        m_click();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (follow !== 1'b1) $display("FAIL reset_follow: got %b expected 1", follow); else n_pass++;
        n_checks++; if (clr_vel !== 1'b1) $display("FAIL reset_clr_vel: got %b expected 1", clr_vel); else n_pass++;
        n_checks++; if (state_o !== FOLLOW) $display("FAIL reset_state: got %0d expected %0d", state_o, FOLLOW); else n_pass++;
        n_checks++; if (bounce_cnt !== 4'd0) $display("FAIL reset_bounce: got %0d expected 0", bounce_cnt); else n_pass++;
        n_checks++;
        if ({step_en, dir_up, load_floor, halve_vel} !== 4'b0000)
            $display("FAIL reset_pulses: got %b expected 0000", {step_en, dir_up, load_floor, halve_vel});
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
    endtask

    task automatic test_glitch();
        int len;
        for (int k = 0; k < 3; k++) begin
            len = (k == 0) ? 2 : int'($urandom_range(1, DEB - 1));
            @(posedge clk); #1;
            mouse_left = 1'b1;
            repeat (len) @(posedge clk);
            #1;
            mouse_left = 1'b0;
            repeat (CLICK_LAT + 4) @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (state_o !== FOLLOW) $display("FAIL glitch_len%0d_state: got %0d expected %0d", len, state_o, FOLLOW);
            else n_pass++;
        end
    endtask

    task automatic test_click_latency();
        @(posedge clk); #1;
        mouse_left = 1'b1;
        repeat (CLICK_LAT - 1) @(posedge clk);
        @(negedge clk);
        n_checks++; if (state_o !== FOLLOW) $display("FAIL click_early: got %0d expected %0d", state_o, FOLLOW); else n_pass++;
        @(negedge clk);
        n_checks++; if (state_o !== FALL) $display("FAIL click_lat: got %0d expected %0d", state_o, FALL); else n_pass++;
        n_checks++;
        if ({follow, clr_vel} !== 2'b00) $display("FAIL click_fall_flags: got %b expected 00", {follow, clr_vel});
        else n_pass++;
        #1;
        mouse_left = 1'b0;
        repeat (DEB + 4) @(posedge clk);
        m_click();
    endtask

    task automatic test_fall_steps();
        int s0, u0, l0, g0, es, eu, el;
        s0 = step_seen; u0 = up_seen; l0 = long_seen; g0 = load_seen;
        for (int k = 0; k < 4; k++) do_vsync(1'b0, 1'b0, 1'b0, es, eu, el);
        @(negedge clk);
        n_checks++; if (step_seen - s0 != 2) $display("FAIL fall_steps: got %0d expected 2", step_seen - s0); else n_pass++;
        n_checks++; if (up_seen - u0 != 0) $display("FAIL fall_dir: got %0d up steps expected 0", up_seen - u0); else n_pass++;
        n_checks++; if (long_seen - l0 != 0) $display("FAIL fall_pulse_len: got %0d long pulses expected 0", long_seen - l0); else n_pass++;
        n_checks++; if (load_seen - g0 != 0) $display("FAIL fall_no_load: got %0d expected 0", load_seen - g0); else n_pass++;
        n_checks++; if (state_o !== FALL) $display("FAIL fall_state: got %0d expected %0d", state_o, FALL); else n_pass++;
    endtask

    task automatic test_impact();
        int s0, es, eu, el;
        while (m_frames != TDIV - 1) do_vsync(1'b0, 1'b0, 1'b0, es, eu, el);
        s0 = step_seen;
        @(posedge clk); #1;
        vsync = 1'b1; at_floor = 1'b1; apex = 1'b0; vel_small = 1'b0;
        @(posedge clk); #1;
        vsync = 1'b0;
        m_frames = 0;
        m_bounce = m_bounce + 1;
        @(negedge clk);
        n_checks++; if (state_o !== IMPACT) $display("FAIL impact_state: got %0d expected %0d", state_o, IMPACT); else n_pass++;
        n_checks++;
        if ({load_floor, halve_vel, step_en} !== 3'b110)
            $display("FAIL impact_pulses: got %b expected 110", {load_floor, halve_vel, step_en});
        else n_pass++;
        n_checks++;
        if (bounce_cnt !== 4'(m_bounce)) $display("FAIL impact_bounce: got %0d expected %0d", bounce_cnt, m_bounce);
        else n_pass++;
        @(negedge clk);
        m_mode = M_RISE;
        n_checks++; if (state_o !== RISE) $display("FAIL impact_to_rise: got %0d expected %0d", state_o, RISE); else n_pass++;
        n_checks++;
        if ({load_floor, halve_vel, dir_up} !== 3'b001)
            $display("FAIL rise_flags: got %b expected 001", {load_floor, halve_vel, dir_up});
        else n_pass++;
        while (m_frames != TDIV - 1) do_vsync(1'b0, 1'b0, 1'b0, es, eu, el);
        do_vsync(1'b0, 1'b1, 1'b0, es, eu, el);
        @(negedge clk);
        n_checks++; if (state_o !== FALL) $display("FAIL apex_state: got %0d expected %0d", state_o, FALL); else n_pass++;
        n_checks++; if (step_seen - s0 != 0) $display("FAIL apex_no_step: got %0d expected 0", step_seen - s0); else n_pass++;
    endtask

    task automatic test_bounce_limit();
        int es, eu, el, guard;
        guard = 0;
        while (m_mode != M_REST && guard < 20) begin
            if (m_mode == M_FALL) do_vsync(1'b1, 1'b0, 1'b0, es, eu, el);
            else                  do_vsync(1'b0, 1'b1, 1'b0, es, eu, el);
            guard++;
        end
        @(negedge clk);
        n_checks++; if (state_o !== REST) $display("FAIL limit_state: got %0d expected %0d", state_o, REST); else n_pass++;
        n_checks++; if (bounce_cnt !== 4'(MAXB)) $display("FAIL limit_bounce: got %0d expected %0d", bounce_cnt, MAXB); else n_pass++;
        n_checks++; if (clr_vel !== 1'b1) $display("FAIL limit_clr_vel: got %b expected 1", clr_vel); else n_pass++;
        do_click();
        @(negedge clk);
        n_checks++; if (state_o !== FOLLOW) $display("FAIL rest_click: got %0d expected %0d", state_o, FOLLOW); else n_pass++;
        n_checks++; if (follow !== 1'b1) $display("FAIL rest_click_follow: got %b expected 1", follow); else n_pass++;
    endtask

    task automatic test_click_tick();
        int s0, es, eu, el, guard;
        do_click();
        guard = 0;
        while (m_mode != M_RISE && guard < 10) begin
            do_vsync(1'b1, 1'b0, 1'b0, es, eu, el);
            guard++;
        end
        while (m_frames != TDIV - 1) do_vsync(1'b0, 1'b0, 1'b0, es, eu, el);
        s0 = step_seen;
        at_floor = 1'b0; apex = 1'b0;
        @(posedge clk); #1;
        mouse_left = 1'b1;
        repeat (CLICK_LAT - 1) @(posedge clk);
        #1;
        vsync = 1'b1;
        @(posedge clk); #1;
        vsync = 1'b0;
        m_frames = 0;
        m_click();
        @(negedge clk);
        n_checks++; if (state_o !== FOLLOW) $display("FAIL clicktick_state: got %0d expected %0d", state_o, FOLLOW); else n_pass++;
        #1;
        mouse_left = 1'b0;
        repeat (DEB + 4) @(posedge clk);
        @(negedge clk);
        n_checks++; if (step_seen - s0 != 0) $display("FAIL clicktick_no_step: got %0d expected 0", step_seen - s0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int es, eu, el;
        do_click();
        do_vsync(1'b0, 1'b0, 1'b0, es, eu, el);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
        @(negedge clk);
        n_checks++; if (state_o !== FOLLOW) $display("FAIL midrst_state: got %0d expected %0d", state_o, FOLLOW); else n_pass++;
        n_checks++;
        if ({follow, clr_vel, step_en} !== 3'b110) $display("FAIL midrst_flags: got %b expected 110", {follow, clr_vel, step_en});
        else n_pass++;
    endtask

    task automatic test_random_flight();
        int s0, u0, l0, h0, x0, o0, es, eu, el;
        for (int i = 0; i < 50; i++) begin
            s0 = step_seen; u0 = up_seen; l0 = load_seen; h0 = halve_seen; x0 = long_seen; o0 = overlap_seen;
            es = 0; eu = 0; el = 0;
            if ($urandom_range(0, 7) == 0 || m_mode == M_FOLLOW && $urandom_range(0, 1) == 0) begin
                do_click();
            end else begin
                do_vsync(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 3) == 0), es, eu, el);
            end
            @(negedge clk);
            n_checks++;
            if (state_o !== m_enc(m_mode)) $display("FAIL rand%0d_state: got %0d expected %0d", i, state_o, m_enc(m_mode));
            else n_pass++;
            n_checks++;
            if (bounce_cnt !== 4'(m_bounce)) $display("FAIL rand%0d_bounce: got %0d expected %0d", i, bounce_cnt, m_bounce);
            else n_pass++;
            n_checks++;
            if (step_seen - s0 != es) $display("FAIL rand%0d_steps: got %0d expected %0d", i, step_seen - s0, es);
            else n_pass++;
            n_checks++;
            if (up_seen - u0 != eu) $display("FAIL rand%0d_dir: got %0d up steps expected %0d", i, up_seen - u0, eu);
            else n_pass++;
            n_checks++;
            if (load_seen - l0 != el || halve_seen - h0 != el)
                $display("FAIL rand%0d_impact: got load %0d halve %0d expected %0d", i, load_seen - l0, halve_seen - h0, el);
            else n_pass++;
            n_checks++;
            if (long_seen - x0 != 0 || overlap_seen - o0 != 0)
                $display("FAIL rand%0d_pulse_shape: got long %0d overlap %0d expected 0", i, long_seen - x0, overlap_seen - o0);
            else n_pass++;
            n_checks++;
            if ({follow, clr_vel} !== {m_mode == M_FOLLOW, m_mode == M_FOLLOW || m_mode == M_REST})
                $display("FAIL rand%0d_flags: got %b expected %b", i, {follow, clr_vel},
                         {m_mode == M_FOLLOW, m_mode == M_FOLLOW || m_mode == M_REST});
            else n_pass++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_glitch();
        test_click_latency();
        test_fall_steps();
        test_impact();
        test_bounce_limit();
        test_click_tick();
        test_reset_mid();
        test_random_flight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
